mux_n_skid: RTL
===============

Name: mux_n_skid

Overview:
Parametrised N-way, WIDTH-bit operand selector with a registered valid/ready output stage and a 2-entry skid buffer. It is the pipelined successor of the combinational 2:1 data mux. It is used at pipeline-stage boundaries of the RV32I core, for example operand and forwarding select, where selection and registering happen together. Backpressure from the next stage must not create a combinational ready path upstream.

Parameters:
WIDTH, 32, data width of each input and of the output
N, 4, number of selectable inputs (N >= 2)
SELW, $clog2(N), select width; localparam, derived from N, not overridable

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
in_data  input  N*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
sel  input  SELW  binary select, sampled with in_data
in_valid  input  1  upstream offers in_data/sel this cycle
in_ready  output  1  block can accept this cycle; driven directly from a register
out_data  output  WIDTH  selected word, registered
out_sel_err  output  1  travels with out_data; high if the word was captured with sel >= N
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data this cycle

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset values, applied at the clock edge while reset=1: out_valid=0, out_data=0, out_sel_err=0, skid buffer empty, in_ready=1 from the first cycle after reset deasserts.
- While reset=1, in_ready is forced to 0 combinationally. Any in_valid offered in that cycle is discarded.
- Reset asserted mid-operation flushes both entries. Held words are lost and out_valid goes to 0 on the next edge.
- Accept: in_fire = in_valid & in_ready. Emit: out_fire = out_valid & out_ready.
- Captured word = in_data[sel*WIDTH +: WIDTH] when sel < N. When sel >= N (non-power-of-2 N), the captured word is input 0 and the stored err bit is 1.
- Latency is 1 cycle: a word accepted at edge t is on out_data with out_valid=1 after edge t.
- Throughput is 1 word/cycle while out_ready=1. Words leave in acceptance order; none are dropped or duplicated.
- Storage: main register M (drives outputs) and skid register S. in_ready = !S_valid, registered.
- States:
  - EMPTY: M and S invalid.
  - ONE: M valid, S invalid.
  - FULL: both valid; in_ready=0.
- EMPTY: in_fire -> load M, go to ONE.
- ONE:
  - in_fire & out_fire -> load M with the new word, stay in ONE.
  - in_fire & !out_fire -> load S, go to FULL.
  - !in_fire & out_fire -> go to EMPTY.
  - Neither -> hold.
- FULL: no accept is possible.
  - out_fire -> move S into M, S invalid, go to ONE.
  - Otherwise hold.
- Stability: while out_valid=1 and out_ready=0, out_data and out_sel_err must not change.
- Combinational paths: out_ready has no combinational path to in_ready. in_data and sel have no combinational path to any output.
- Selection width: only the SELW-bit sel is used, never extended.

Decomposition:
- Shared header rv_defs.vh: a clog2 constant function (or use of $clog2) and the default XLEN=32 used for WIDTH. No other shared constants.
- One natural sub-module: mux_n. It is a purely combinational N:1, WIDTH-bit selector with a binary sel and an err output for sel >= N. It is instantiated once, feeding the M/S load path, and is reusable by the forwarding unit.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with in_valid=1 -> in_ready=0 during reset; out_valid=0, out_data=0 afterwards; nothing emitted.
- Streaming: N=4, out_ready=1, sel=0,1,2,3 on consecutive cycles with in_data words 0xA0,0xB1,0xC2,0xD3 in slot k -> out_data 0xA0,0xB1,0xC2,0xD3 on the 4 following cycles; in_ready stays 1.
- Backpressure/skid: out_ready=0, offer 0x11 (sel=1) then 0x22 (sel=2) -> FULL, in_ready=0, out_data holds 0x11. Raise out_ready -> 0x11 then 0x22 in order; in_ready returns to 1 after the first out_fire.
- Simultaneous accept/emit in ONE: out_ready=1, in_valid=1 continuously with a random pattern -> S never used; in_ready never drops.
- Out-of-range select: N=3, sel=3, slot0=0x5 -> out_data=0x5, out_sel_err=1; the next word with sel=2 has out_sel_err=0.
- Reset mid-operation: FULL state, then reset=1 for one cycle -> out_valid=0, in_ready=1 next cycle; the flushed words never appear.

Source files
------------

// File: rtl/mux_n_skid_pkg.sv
// Shared constants and FSM encoding for the N-way select + skid output stage.
package mux_n_skid_pkg;

  localparam int XLEN = 32;

  // Occupancy of the main (M) and skid (S) registers.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_n_skid_mux_n.sv
// Combinational N:1 WIDTH-bit selector; err flags a select with no matching input.
module mux_n
  import mux_n_skid_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int N     = 4,
  localparam int SELW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               err
);

  logic w_hit;

  // Out-of-range selects fall back to input 0 so the word is still defined.
  always_comb begin
    out_data = in_data[WIDTH-1:0];
    w_hit    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        out_data = in_data[k*WIDTH +: WIDTH];
        w_hit    = 1'b1;
      end
    end
    err = ~w_hit;
  end

endmodule

// File: rtl/mux_n_skid.sv
// N-way operand select registered into a valid/ready stage with a 2-entry skid buffer.
module mux_n_skid
  import mux_n_skid_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int N     = 4,
  localparam int SELW = (N > 1) ? clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sel_err,
  output logic               out_valid,
  input  logic               out_ready
);

  skid_state_t      r_state, w_state_nxt;
  logic             r_in_ready, r_out_valid;
  logic [WIDTH-1:0] r_m_data, r_s_data;
  logic             r_m_err, r_s_err;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;
  logic             w_in_fire, w_out_fire;
  logic             w_ld_m_in, w_ld_m_s, w_ld_s;

  mux_n #(.WIDTH(WIDTH), .N(N)) u_mux (
    .in_data  (in_data),
    .sel      (sel),
    .out_data (w_sel_data),
    .err      (w_sel_err)
  );

  // Ready is a flop; reset gating only masks it while the flush is in progress.
  assign in_ready    = r_in_ready & ~reset;
  assign out_valid   = r_out_valid;
  assign out_data    = r_m_data;
  assign out_sel_err = r_m_err;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_ld_m_in   = 1'b0;
    w_ld_m_s    = 1'b0;
    w_ld_s      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_ld_m_in   = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({w_in_fire, w_out_fire})
          2'b11: w_ld_m_in = 1'b1;
          2'b10: begin
            w_ld_s      = 1'b1;
            w_state_nxt = ST_FULL;
          end
          2'b01: w_state_nxt = ST_EMPTY;
          default: ;
        endcase
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_ld_m_s    = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_m_data    <= '0;
      r_m_err     <= 1'b0;
      r_s_data    <= '0;
      r_s_err     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      if (w_ld_m_in) begin
        r_m_data <= w_sel_data;
        r_m_err  <= w_sel_err;
      end else if (w_ld_m_s) begin
        r_m_data <= r_s_data;
        r_m_err  <= r_s_err;
      end
      if (w_ld_s) begin
        r_s_data <= w_sel_data;
        r_s_err  <= w_sel_err;
      end
    end
  end

endmodule
